ir_queue: RTL
=============

// Module: ir_queue
// PURPOSE
// - Parametrised instruction holding queue. It replaces the single-entry hold register that sits
//   between the instruction-memory read port and the control/decode logic.
// - Buffers up to DEPTH fetched instructions, each with its PC, in a circular FIFO.
// - Presents the head entry already split into MIPS fields, plus a legality flag.
// - Lets fetch run ahead of execute. Optionally bypasses the queue when it is empty.
// PARAMETERS
// - DEPTH      4  number of entries; power of two, >= 2
// - BYPASS     1  1: when empty, a pushed word is visible at the head in the same cycle
//                 0: a pushed word is visible at the head only from the next cycle
// - POP_THRU   1  1: push_ready_o stays high when full if pop_i is high in the same cycle
// - CW         $clog2(DEPTH+1)  derived; width of count_o
// PORTS
// - clk           in   1   rising-edge clock
// - reset_n_i     in   1   asynchronous active-low reset
// - flush_i       in   1   discard all entries (branch/jump redirect)
// - push_valid_i  in   1   instruction word valid from fetch
// - push_ready_o  out  1   queue can accept a push this cycle
// - push_instr_i  in   32  fetched instruction word
// - push_pc_i     in   32  PC of the fetched word
// - pop_i         in   1   consumer takes the head entry this cycle
// - head_valid_o  out  1   head entry present
// - head_instr_o  out  32  head instruction word
// - head_pc_o     out  32  head PC
// - opcode_o      out  6   head[31:26]
// - rs_o          out  5   head[25:21]
// - rt_o          out  5   head[20:16]
// - rd_o          out  5   head[15:11]
// - shift_o       out  5   head[10:6]
// - funct_o       out  6   head[5:0]
// - imm_o         out  16  head[15:0]
// - target_o      out  26  head[25:0]
// - illegal_o     out  1   head is valid and not a supported instruction
// - count_o       out  CW  number of stored entries; excludes a bypassed word
// BEHAVIOUR
// Reset (async, reset_n_i=0):
// - rd_ptr=0, wr_ptr=0, count=0; storage contents are don't-care.
// - push_ready_o=1, head_valid_o=0, illegal_o=0, count_o=0.
// - All head and field outputs are 0.
// - Reset asserted mid-operation drops all entries immediately. It does not wait for a clock edge.
// Occupancy states, derived from count:
// - EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
// - Any state goes to EMPTY when flush_i=1.
// Push and pop rules:
// - push_ready_o = !flush_i && (count<DEPTH || (POP_THRU && pop_i && count==DEPTH)).
// - A push is accepted when push_valid_i && push_ready_o. The word is written at wr_ptr, then wr_ptr advances.
// - A pop takes effect when pop_i && head_valid_o && !flush_i.
//   - If the head came from storage, rd_ptr advances.
//   - If the head was bypassed, nothing is stored.
// - pop_i while head_valid_o=0 is ignored. There is no underflow.
// - A push while not ready is dropped. Fetch must hold the word; there is no overflow.
// - Push and pop in the same cycle: count is unchanged, both pointers advance.
// - This applies in FULL only when POP_THRU=1.
// - Pointers wrap modulo DEPTH. count saturates at neither end; the rules above make it unreachable.
// Head:
// - Normally head = mem[rd_ptr], head_valid_o = (count!=0) && !flush_i.
// - BYPASS=1 with count==0: head = push_instr_i/push_pc_i and head_valid_o = push_valid_i && !flush_i,
//   combinationally. If pop_i is also high, the word is consumed and not stored (count stays 0).
// - head_valid_o=0: all field outputs are 0 and illegal_o=0.
// Flush:
// - On the next edge: count=0, rd_ptr=wr_ptr=0.
// - Any push or pop in the flush cycle is ignored.
// - Flush has priority over push and pop.
// Legality (illegal_o=1 when head_valid_o and none of the following matches):
// - opcode in {01..0F, 20,21,22,23,24,25,26, 28,29,2A,2B,2E} (hex).
// - opcode=00 and funct in {00,02,03,04,06,07,08,09,0C,0D,10..13,18..1B,20..27,2A,2B}.
// - opcode=01 additionally requires rt in {00,01,10,11}.
// Latency: push to head is 0 cycles with bypass on an empty queue, otherwise 1 cycle.
// TESTING
// 1. Reset mid-run with count=3 -> count_o=0, head_valid_o=0, push_ready_o=1 with no clock edge.
// 2. BYPASS=1, empty; push 0x24020005 (addiu) with pop_i=1 -> head_valid_o=1, opcode_o=09,
//    imm_o=0005, illegal_o=0 in the same cycle; count_o stays 0.
// 3. Push 4 words (DEPTH=4) with no pop -> count_o=4, push_ready_o=0.
//    A 5th push with pop_i=0 is dropped.
//    With pop_i=1 (POP_THRU=1) it is accepted; pops return the words in FIFO order, including across pointer wrap.
// 4. Flush with count=2 while push_valid_i=1 and pop_i=1 -> next cycle count_o=0 and the pushed word is absent.
// 5. Heads 0x0000003F (SPECIAL funct 3F), 0x04050000 (REGIMM rt=05), 0xFC000000
//    -> illegal_o=1 for each. Head 0x00851021 (addu) -> illegal_o=0, rd_o=2, funct_o=21.
// 6. Random push/pop/flush for 10k cycles against a queue model -> head and count_o match every cycle.

Source files
------------

// File: rtl/ir_queue.sv
// ir_queue: instruction holding queue between the instruction-memory read port
// and control/decode. A circular FIFO of DEPTH {instr, pc} entries. The head is
// presented pre-split into MIPS fields with a legality flag. An optional
// empty-queue bypass shows a pushed word at the head in the same cycle.
//
// Ports
//   clk            rising-edge clock
//   reset_n_i      asynchronous active-low reset
//   flush_i        discard all entries (branch/jump redirect); beats push/pop
//   push_valid_i   fetch presents push_instr_i / push_pc_i
//   push_ready_o   queue accepts a push this cycle
//   pop_i          consumer takes the head entry this cycle
//   head_valid_o   head entry present
//   head_instr_o   head instruction word (0 when no head)
//   head_pc_o      head PC (0 when no head)
//   opcode_o .. target_o   head split into MIPS fields (0 when no head)
//   illegal_o      head is valid but not a supported instruction
//   count_o        stored entries; a bypassed word is not counted
module ir_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          POP_THRU = 1'b1,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n_i,
  input  logic          flush_i,
  input  logic          push_valid_i,
  output logic          push_ready_o,
  input  logic [31:0]   push_instr_i,
  input  logic [31:0]   push_pc_i,
  input  logic          pop_i,
  output logic          head_valid_o,
  output logic [31:0]   head_instr_o,
  output logic [31:0]   head_pc_o,
  output logic [5:0]    opcode_o,
  output logic [4:0]    rs_o,
  output logic [4:0]    rt_o,
  output logic [4:0]    rd_o,
  output logic [4:0]    shift_o,
  output logic [5:0]    funct_o,
  output logic [15:0]   imm_o,
  output logic [25:0]   target_o,
  output logic          illegal_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  occ_e          occ_c;
  logic          bypass_c;
  logic          push_acc_c;
  logic          pop_acc_c;
  logic          store_c;
  logic          pop_mem_c;
  entry_t        head_c;
  entry_t        shown_c;

  // Supported-instruction decode on the raw head word.
  function automatic logic is_legal(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic       ok;
    op = w[31:26];
    fn = w[5:0];
    rt = w[20:16];
    ok = 1'b0;
    case (op) inside
      6'h00: begin
        case (fn) inside
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h08, 6'h09, 6'h0C, 6'h0D,
          [6'h10:6'h13], [6'h18:6'h1B], [6'h20:6'h27],
          6'h2A, 6'h2B: ok = 1'b1;
          default:      ok = 1'b0;
        endcase
      end
      // REGIMM: only BLTZ/BGEZ/BLTZAL/BGEZAL
      6'h01: ok = (rt inside {5'h00, 5'h01, 5'h10, 5'h11});
      [6'h02:6'h0F],
      [6'h20:6'h26],
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Occupancy class derived from the stored count.
  always_comb begin
    occ_c = OCC_PARTIAL;
    if (count_q == '0)                occ_c = OCC_EMPTY;
    else if (count_q == CW'(DEPTH))   occ_c = OCC_FULL;
  end

  // Handshake, head selection and pointer/count enables.
  always_comb begin
    bypass_c     = BYPASS && (occ_c == OCC_EMPTY);
    push_ready_o = !flush_i &&
                   ((occ_c != OCC_FULL) || (POP_THRU && pop_i));
    head_c       = mem[rd_ptr_q];
    head_valid_o = 1'b0;
    if (bypass_c) begin
      head_c       = '{instr: push_instr_i, pc: push_pc_i};
      head_valid_o = reset_n_i && push_valid_i && !flush_i;
    end else begin
      head_valid_o = reset_n_i && (occ_c != OCC_EMPTY) && !flush_i;
    end
    push_acc_c = push_valid_i && push_ready_o;
    pop_acc_c  = pop_i && head_valid_o;
    // A bypassed word that is popped in the same cycle is never written.
    store_c    = push_acc_c && !(bypass_c && pop_acc_c);
    pop_mem_c  = pop_acc_c && !bypass_c;
  end

  // Field split; everything reads zero when there is no head.
  always_comb begin
    shown_c      = head_valid_o ? head_c : '0;
    head_instr_o = shown_c.instr;
    head_pc_o    = shown_c.pc;
    opcode_o     = shown_c.instr[31:26];
    rs_o         = shown_c.instr[25:21];
    rt_o         = shown_c.instr[20:16];
    rd_o         = shown_c.instr[15:11];
    shift_o      = shown_c.instr[10:6];
    funct_o      = shown_c.instr[5:0];
    imm_o        = shown_c.instr[15:0];
    target_o     = shown_c.instr[25:0];
    illegal_o    = head_valid_o && !is_legal(shown_c.instr);
  end

  assign count_o = count_q;

  // Pointers and count; flush returns to an empty, rewound queue.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (store_c)   wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_mem_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(store_c) - CW'(pop_mem_c);
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (store_c) mem[wr_ptr_q] <= '{instr: push_instr_i, pc: push_pc_i};
  end

endmodule
